ahb_fpga_sram_bridge: RTL and testbench



---
 rtl/ahb_pkg.sv | 30 +++
 rtl/ahb_sram_wbuf.sv | 55 +++++
 rtl/ahb_fpga_sram_bridge.sv | 101 ++++++++++
 tb/tb_ahb_fpga_sram_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size encodings and the byte-lane
// strobe decode used by the SRAM bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Sizes above a word cannot exist on a 32-bit bus; treat them as a full word.
  function automatic logic [3:0] ahb_byte_strb(input logic [2:0] hsize,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer for the AHB/SRAM bridge: holds the last write until
// it can be drained and merges it byte-wise into read data.
module ahb_sram_wbuf #(
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          capture,
  input  logic          drain,
  input  logic [AW-1:0] cap_addr,
  input  logic [3:0]    cap_strb,
  input  logic [31:0]   cap_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [31:0]   sram_rdata,
  output logic          buf_valid,
  output logic [AW-1:0] buf_addr,
  output logic [3:0]    buf_strb,
  output logic [31:0]   buf_data,
  output logic [31:0]   rd_data
);

  logic hit;

  // Capture beats drain so back-to-back writes keep the newer entry valid.
  always_ff @(posedge CLK) begin
    if (RESET)        buf_valid <= 1'b0;
    else if (capture) buf_valid <= 1'b1;
    else if (drain)   buf_valid <= 1'b0;
  end

  // NOTE: payload registers carry no reset; buf_valid alone qualifies them,
  // which keeps reset fan-out off the wide data path.
  always_ff @(posedge CLK) begin
    if (capture) begin
      buf_addr <= cap_addr;
      buf_strb <= cap_strb;
      buf_data <= cap_data;
    end
  end

  assign hit = rd_en & buf_valid & (buf_addr == rd_addr);

  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      for (int k = 0; k < 4; k++) begin
        rd_data[8*k +: 8] = (hit && buf_strb[k]) ? buf_data[8*k +: 8]
                                                 : sram_rdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_fpga_sram_bridge.sv
// Zero-wait-state AHB-Lite slave driving a one-cycle registered FPGA block
// RAM; writes are posted through a one-entry buffer and retire in idle slots.
module ahb_fpga_sram_bridge
  import ahb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          HSEL,
  input  logic [AW+1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  logic          acc, rd_acc, wr_acc;
  logic          rd_pend, wr_pend;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0]    wr_strb;
  logic          capture, drain;
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_strb;
  logic [31:0]   buf_data;

  assign acc    = HSEL & HREADY & (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
    end else if (HREADY) begin
      rd_pend <= rd_acc;
      wr_pend <= wr_acc;
    end
  end

  always_ff @(posedge CLK) begin
    if (HREADY) begin
      rd_addr <= HADDR[AW+1:2];
      wr_addr <= HADDR[AW+1:2];
      wr_strb <= ahb_byte_strb(HSIZE, HADDR[1:0]);
    end
  end

  assign capture = wr_pend & HREADY;
  assign drain   = buf_valid & ~rd_acc & ~RESET;

  ahb_sram_wbuf #(.AW(AW)) u_wbuf (
    .CLK        (CLK),
    .RESET      (RESET),
    .capture    (capture),
    .drain      (drain),
    .cap_addr   (wr_addr),
    .cap_strb   (wr_strb),
    .cap_data   (HWDATA),
    .rd_en      (rd_pend & ~RESET),
    .rd_addr    (rd_addr),
    .sram_rdata (SRAMRDATA),
    .buf_valid  (buf_valid),
    .buf_addr   (buf_addr),
    .buf_strb   (buf_strb),
    .buf_data   (buf_data),
    .rd_data    (HRDATA)
  );

  // Reads own the SRAM port; the buffered write only takes otherwise idle slots.
  always_comb begin
    SRAMCS   = 1'b0;
    SRAMWEN  = 4'b0000;
    SRAMADDR = buf_addr;
    if (!RESET) begin
      if (rd_acc) begin
        SRAMCS   = 1'b1;
        SRAMADDR = HADDR[AW+1:2];
      end else if (drain) begin
        SRAMCS  = 1'b1;
        SRAMWEN = buf_strb;
      end
    end
  end

  assign SRAMWDATA = buf_data;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_fpga_sram_bridge.sv
// Self-checking bench: table of bus cycles with expected SRAM-port activity,
// a reference memory feeding a read-data scoreboard, and multi-cycle sequences.
module tb_ahb_fpga_sram_bridge;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] S_B = 3'd0, S_H = 3'd1, S_W = 3'd2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [17:0] HADDR = '0;
  logic [1:0]  HTRANS = T_IDLE;
  logic [2:0]  HSIZE = S_W;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT, HRESP, SRAMCS;
  logic [31:0] HRDATA, SRAMWDATA;
  logic [15:0] SRAMADDR;
  logic [3:0]  SRAMWEN;
  logic [31:0] SRAMRDATA = '0;

  ahb_fpga_sram_bridge #(.AW(16)) dut (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA), .SRAMWEN(SRAMWEN),
    .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
  );

  always #5 CLK = ~CLK;

  logic [31:0] sram_mem [0:65535];
  logic [31:0] ref_mem  [0:65535];
  int          w40_cnt = 0;

  // Behavioural block RAM: one-cycle registered read, byte-enabled write.
  always @(posedge CLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) SRAMRDATA <= sram_mem[SRAMADDR];
      else begin
        for (int k = 0; k < 4; k++)
          if (SRAMWEN[k]) sram_mem[SRAMADDR][8*k +: 8] <= SRAMWDATA[8*k +: 8];
        if (SRAMADDR == 16'h0040) w40_cnt++;
        SRAMRDATA <= 32'h5EED_0BAD;
      end
    end else begin
      SRAMRDATA <= 32'h5EED_0BAD;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb [$];
  logic        p_rd = 1'b0, p_wr = 1'b0;
  logic [17:0] p_addr = '0;
  logic [2:0]  p_size = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] a);
    if (size == S_B) return 4'(1 << a);
    if (size == S_H) return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // One bus cycle: drive an address phase plus the data for the previous one.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [17:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    logic [3:0]  s;
    logic [31:0] e;
    logic        is_rd, is_wr;
    @(posedge CLK); #1;
    RESET = 1'b0; HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr;
    HSIZE = size; HWDATA = wdata;
    if (p_wr) begin
      s = lanes(p_size, p_addr[1:0]);
      for (int k = 0; k < 4; k++)
        if (s[k]) ref_mem[p_addr[17:2]][8*k +: 8] = wdata[8*k +: 8];
    end
    is_rd = sel && trans[1] && !wr;
    is_wr = sel && trans[1] && wr;
    if (is_rd) sb.push_back(ref_mem[addr[17:2]]);
    @(negedge CLK);
    check("hreadyout", 32'(HREADYOUT), 32'd1);
    check("hresp", 32'(HRESP), 32'd0);
    if (p_rd) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("hrdata", HRDATA, e);
      end
    end else begin
      check("hrdata_idle", HRDATA, 32'd0);
    end
    p_rd = is_rd; p_wr = is_wr; p_addr = addr; p_size = size;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RESET = 1'b1; HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0;
      @(negedge CLK);
      check("rst_cs", 32'(SRAMCS), 32'd0);
      check("rst_wen", 32'(SRAMWEN), 32'd0);
      check("rst_hrdata", HRDATA, 32'd0);
      check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    end
    sb.delete();
    p_rd = 1'b0; p_wr = 1'b0;
  endtask

  task automatic check_sram(input string tag, input logic cs, input logic [3:0] wen,
                            input logic [15:0] addr, input logic [31:0] wdata);
    check({tag, "_cs"}, 32'(SRAMCS), 32'(cs));
    check({tag, "_wen"}, 32'(SRAMWEN), 32'(wen));
    if (cs) check({tag, "_addr"}, 32'(SRAMADDR), 32'(addr));
    if (wen != 4'b0000)
      check({tag, "_wdata"}, SRAMWDATA & lane_mask(wen), wdata & lane_mask(wen));
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [17:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_cs;
    logic [3:0]  exp_wen;
    logic [15:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] old40;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = {~i[15:0], i[15:0] ^ 16'h5A5A};
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[8] = 32'hDEADBEEF;
    ref_mem[8]  = 32'hDEADBEEF;

    //         sel   trans   wr    addr       size wdata          cs    wen      addr      wdata
    tbl.push_back('{1'b1, T_NS,   1'b1, 18'h00010, S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h11223344, 1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b1, 4'hF, 16'h0004, 32'h11223344});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_NS,   1'b1, 18'h00021, S_B, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_NS,   1'b0, 18'h00020, S_W, 32'h1234AB78, 1'b1, 4'h0, 16'h0008, 32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b1, 4'h2, 16'h0008, 32'h0000AB00});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_NS,   1'b1, 18'h00040, S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_SEQ,  1'b1, 18'h00044, S_W, 32'hA5A5A5A5, 1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h5A5A5A5A, 1'b1, 4'hF, 16'h0010, 32'hA5A5A5A5});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b1, 4'hF, 16'h0011, 32'h5A5A5A5A});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_NS,   1'b0, 18'h00040, S_W, 32'h0,        1'b1, 4'h0, 16'h0010, 32'h0});
    tbl.push_back('{1'b1, T_SEQ,  1'b0, 18'h00044, S_W, 32'h0,        1'b1, 4'h0, 16'h0011, 32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b0, T_NS,   1'b0, 18'h00040, S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_BUSY, 1'b0, 18'h00040, S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_NS,   1'b1, 18'h3FFFE, S_H, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'hCAFE0000, 1'b0, 4'h0, 16'h0,    32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b1, 4'hC, 16'hFFFF, 32'hCAFE0000});
    tbl.push_back('{1'b1, T_NS,   1'b0, 18'h3FFFC, S_W, 32'h0,        1'b1, 4'h0, 16'hFFFF, 32'h0});
    tbl.push_back('{1'b1, T_IDLE, 1'b0, 18'h0,     S_W, 32'h0,        1'b0, 4'h0, 16'h0,    32'h0});

    reset_cycles(2);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sel, tbl[i].trans, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata);
      check_sram($sformatf("row%0d", i), tbl[i].exp_cs, tbl[i].exp_wen,
                 tbl[i].exp_addr, tbl[i].exp_wdata);
    end

    // Buffered halfword write starved by eight back-to-back reads.
    step(1'b1, T_NS, 1'b1, 18'h00082, S_H, 32'h0);
    check_sram("hw_addr", 1'b0, 4'h0, 16'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, T_NS, 1'b0, (i % 3 == 2) ? 18'h00084 : 18'h00080, S_W,
           (i == 0) ? 32'hBEEF0000 : 32'h0);
      check_sram($sformatf("starve%0d", i), 1'b1, 4'h0,
                 (i % 3 == 2) ? 16'h0021 : 16'h0020, 32'h0);
    end
    step(1'b1, T_IDLE, 1'b0, 18'h0, S_W, 32'h0);
    check_sram("retire", 1'b1, 4'hC, 16'h0020, 32'hBEEF0000);
    step(1'b1, T_IDLE, 1'b0, 18'h0, S_W, 32'h0);
    check_sram("retired", 1'b0, 4'h0, 16'h0, 32'h0);

    // Reset with a write sitting in the buffer and a read in its data phase.
    old40 = ref_mem[16'h0040];
    step(1'b1, T_NS, 1'b1, 18'h00100, S_W, 32'h0);
    step(1'b1, T_IDLE, 1'b0, 18'h0, S_W, 32'h77777777);
    step(1'b1, T_NS, 1'b0, 18'h00104, S_W, 32'h0);
    check_sram("pre_rst_rd", 1'b1, 4'h0, 16'h0041, 32'h0);
    reset_cycles(1);
    ref_mem[16'h0040] = old40;
    step(1'b1, T_NS, 1'b0, 18'h00100, S_W, 32'h0);
    check_sram("post_rst_rd", 1'b1, 4'h0, 16'h0040, 32'h0);
    step(1'b1, T_IDLE, 1'b0, 18'h0, S_W, 32'h0);
    check_sram("post_rst_idle", 1'b0, 4'h0, 16'h0, 32'h0);
    step(1'b1, T_IDLE, 1'b0, 18'h0, S_W, 32'h0);
    check_sram("post_rst_idle2", 1'b0, 4'h0, 16'h0, 32'h0);
    check("discarded_write", 32'(w40_cnt), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
